// File: rtl/seq_det_pkg.sv
// Shared constants and state encoding for the parameterised serial pattern detector.
package seq_det_pkg;

  localparam logic [3:0] DEFAULT_PATTERN = 4'b1100;

  localparam bit OVERLAP_OFF = 1'b0;
  localparam bit OVERLAP_ON  = 1'b1;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_ARMED = 1'b1
  } det_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; a clear on the same edge as an increment leaves the count at one.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX = {W{1'b1}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= W'(inc);
    end else if (inc && count != MAX) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Serial bit-pattern detector with runtime-loadable pattern, optional overlap
// and a saturating match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(DEFAULT_PATTERN),
  parameter bit                 OVERLAP = OVERLAP_ON,
  parameter int                 CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               bit_in,
  input  logic               bit_valid,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pat_in,
  input  logic               clear_count,
  output logic               pattern_detected,
  output logic [CNT_W-1:0]   match_count,
  output logic               armed
);

  localparam int             FW   = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0]  FULL = FW'(PAT_LEN);

  logic [PAT_LEN-1:0] history;
  logic [PAT_LEN-1:0] active_pat;
  logic [PAT_LEN-1:0] next_hist;
  logic [FW-1:0]      fill;
  logic [FW-1:0]      next_fill;
  logic               consume;
  logic               match;
  det_state_t         state;

  // A load takes the edge exclusively, so any bit offered alongside it is dropped.
  always_comb begin
    consume   = bit_valid && !pat_load;
    next_hist = {history[PAT_LEN-2:0], bit_in};
    next_fill = (fill == FULL) ? FULL : fill + 1'b1;
    match     = consume && (next_hist == active_pat) && (next_fill == FULL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      history          <= '0;
      fill             <= '0;
      active_pat       <= PATTERN;
      pattern_detected <= 1'b0;
    end else begin
      pattern_detected <= match;
      if (pat_load) begin
        active_pat <= pat_in;
        fill       <= '0;
      end else if (bit_valid) begin
        history <= next_hist;
        fill    <= (match && OVERLAP == OVERLAP_OFF) ? '0 : next_fill;
      end
    end
  end

  assign state = (fill == FULL) ? ST_ARMED : ST_FILL;
  assign armed = (state == ST_ARMED);

  sat_counter #(
    .W(CNT_W)
  ) u_count (
    .clk   (clk),
    .rst   (rst),
    .inc   (match),
    .clr   (clear_count),
    .count (match_count)
  );

endmodule
